// File: rtl/count_sequence_checker.sv
// count_sequence_checker: watches a 3-bit counter stream, decides whether it is
// a binary or reflected-Gray sequence, locks onto it, then tracks the decoded
// position and flags/counts any break in the sequence.
module count_sequence_checker #(
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             Enable,
  input  logic [2:0]       CountIn,
  output logic             Locked,
  output logic             ModeDet,
  output logic [2:0]       Position,
  output logic             SeqError,
  output logic             WrapPulse,
  output logic [ERR_W-1:0] ErrCount
);

  typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;
  typedef enum logic [1:0] {TR_NONE, TR_BIN, TR_GRAY, TR_BOTH} trans_t;

  localparam logic [2:0] LOCK_N = 3'(LOCK_COUNT);

  state_t           state, state_n;
  logic [2:0]       prev, prev_n;
  logic [2:0]       cnt, cnt_n;
  logic             cand_vld, cand_vld_n;
  logic             cand_mode, cand_mode_n;
  logic             locked_n, mode_n, seq_err_n, wrap_n;
  logic [2:0]       pos_n;
  logic [ERR_W-1:0] err_n;

  trans_t           trans;
  logic             tmode;
  logic [2:0]       exp_c;
  logic [2:0]       dec_c;

  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

  function automatic logic [2:0] bin2gray(input logic [2:0] b);
    return b ^ {1'b0, b[2:1]};
  endfunction

  function automatic logic [2:0] bin_succ(input logic [2:0] p);
    return p + 3'd1;
  endfunction

  function automatic logic [2:0] gray_succ(input logic [2:0] p);
    return bin2gray(gray2bin(p) + 3'd1);
  endfunction

  // "both" only occurs at 000 and 110, where the two successors coincide
  function automatic trans_t classify(input logic [2:0] p, input logic [2:0] c);
    logic b, g;
    b = (c == bin_succ(p));
    g = (c == gray_succ(p));
    if (b && g) return TR_BOTH;
    else if (b) return TR_BIN;
    else if (g) return TR_GRAY;
    else        return TR_NONE;
  endfunction

  // Error counter sticks at all-ones instead of wrapping
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] e);
    return (&e) ? e : e + 1'b1;
  endfunction

  // Next-state and next-output decode for one enabled sample
  always_comb begin
    state_n     = state;
    prev_n      = prev;
    cnt_n       = cnt;
    cand_vld_n  = cand_vld;
    cand_mode_n = cand_mode;
    locked_n    = Locked;
    mode_n      = ModeDet;
    pos_n       = Position;
    seq_err_n   = 1'b0;
    wrap_n      = 1'b0;
    err_n       = ErrCount;
    trans       = classify(prev, CountIn);
    tmode       = (trans == TR_GRAY);
    exp_c       = ModeDet ? gray_succ(prev) : bin_succ(prev);
    dec_c       = ModeDet ? gray2bin(CountIn) : CountIn;

    case (state)
      IDLE: begin
        prev_n      = CountIn;
        cnt_n       = 3'd0;
        cand_vld_n  = 1'b0;
        cand_mode_n = 1'b0;
        state_n     = ACQ;
      end

      ACQ: begin
        prev_n = CountIn;
        case (trans)
          TR_BOTH: ;
          TR_BIN, TR_GRAY: begin
            if (!cand_vld || (cand_mode == tmode)) cnt_n = cnt + 3'd1;
            else                                   cnt_n = 3'd1;
            cand_vld_n  = 1'b1;
            cand_mode_n = tmode;
          end
          default: begin
            cnt_n       = 3'd0;
            cand_vld_n  = 1'b0;
            cand_mode_n = 1'b0;
          end
        endcase
        if (cand_vld_n && (cnt_n == LOCK_N)) begin
          state_n  = TRACK;
          locked_n = 1'b1;
          mode_n   = cand_mode_n;
          pos_n    = cand_mode_n ? gray2bin(CountIn) : CountIn;
        end
      end

      TRACK: begin
        prev_n = CountIn;
        if (CountIn == exp_c) begin
          pos_n  = dec_c;
          wrap_n = (Position == 3'd7) && (dec_c == 3'd0);
        end else begin
          seq_err_n   = 1'b1;
          err_n       = sat_inc(ErrCount);
          locked_n    = 1'b0;
          pos_n       = 3'd0;
          cnt_n       = 3'd0;
          cand_vld_n  = 1'b0;
          cand_mode_n = 1'b0;
          state_n     = ACQ;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State and output registers; Enable=0 freezes everything and clears pulses
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state     <= IDLE;
      prev      <= 3'd0;
      cnt       <= 3'd0;
      cand_vld  <= 1'b0;
      cand_mode <= 1'b0;
      Locked    <= 1'b0;
      ModeDet   <= 1'b0;
      Position  <= 3'd0;
      SeqError  <= 1'b0;
      WrapPulse <= 1'b0;
      ErrCount  <= '0;
    end else if (Enable) begin
      state     <= state_n;
      prev      <= prev_n;
      cnt       <= cnt_n;
      cand_vld  <= cand_vld_n;
      cand_mode <= cand_mode_n;
      Locked    <= locked_n;
      ModeDet   <= mode_n;
      Position  <= pos_n;
      SeqError  <= seq_err_n;
      WrapPulse <= wrap_n;
      ErrCount  <= err_n;
    end else begin
      SeqError  <= 1'b0;
      WrapPulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed bench for count_sequence_checker: two instances share the stimulus,
// one with an 8-bit error counter and one with a 2-bit counter for saturation.
module tb_count_sequence_checker;

  logic       Clk = 1'b0;
  logic       nReset;
  logic       Enable;
  logic [2:0] CountIn;

  logic       Locked, ModeDet, SeqError, WrapPulse;
  logic [2:0] Position;
  logic [7:0] ErrCount;

  logic       s_Locked, s_ModeDet, s_SeqError, s_WrapPulse;
  logic [2:0] s_Position;
  logic [1:0] s_ErrCount;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  count_sequence_checker #(.LOCK_COUNT(3), .ERR_W(8)) u_dut (
    .Clk(Clk), .nReset(nReset), .Enable(Enable), .CountIn(CountIn),
    .Locked(Locked), .ModeDet(ModeDet), .Position(Position),
    .SeqError(SeqError), .WrapPulse(WrapPulse), .ErrCount(ErrCount)
  );

  count_sequence_checker #(.LOCK_COUNT(3), .ERR_W(2)) u_sat (
    .Clk(Clk), .nReset(nReset), .Enable(Enable), .CountIn(CountIn),
    .Locked(s_Locked), .ModeDet(s_ModeDet), .Position(s_Position),
    .SeqError(s_SeqError), .WrapPulse(s_WrapPulse), .ErrCount(s_ErrCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one sample and settle just after the sampling edge
  task automatic step(input logic en, input logic [2:0] c);
    Enable  = en;
    CountIn = c;
    @(posedge Clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic lk, input logic md, input logic [2:0] pos,
                      input logic se, input logic wp, input logic [7:0] ec);
    chk({tag, ".Locked"},    Locked,    lk);
    chk({tag, ".ModeDet"},   ModeDet,   md);
    chk({tag, ".Position"},  Position,  pos);
    chk({tag, ".SeqError"},  SeqError,  se);
    chk({tag, ".WrapPulse"}, WrapPulse, wp);
    chk({tag, ".ErrCount"},  ErrCount,  ec);
  endtask

  logic [2:0] relock [5] = '{3'b111, 3'b000, 3'b001, 3'b010, 3'b011};
  logic [2:0] bseq   [7] = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b000, 3'b001, 3'b010};

  initial begin
    nReset  = 1'b0;
    Enable  = 1'b0;
    CountIn = 3'd0;
    step(1'b0, 3'd0);
    step(1'b0, 3'd0);
    outs("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.sat_ErrCount", s_ErrCount, 0);
    nReset = 1'b1;

    // Binary lock: 001 is ambiguous, so lock lands on the 100 sample
    step(1, 3'b000); chk("bin.s0.Locked", Locked, 0);
    step(1, 3'b001); chk("bin.s1.Locked", Locked, 0);
    step(1, 3'b010); chk("bin.s2.Locked", Locked, 0);
    step(1, 3'b011); chk("bin.s3.Locked", Locked, 0);
    step(1, 3'b100); outs("bin.lock", 1, 0, 4, 0, 0, 0);

    // Sequence break while locked binary
    step(1, 3'b101); outs("bin.pos5", 1, 0, 5, 0, 0, 0);
    step(1, 3'b111); outs("err1", 0, 0, 0, 1, 0, 1);
    chk("err1.sat_ErrCount", s_ErrCount, 1);
    step(1, 3'b000); chk("err1.pulse_end", SeqError, 0); chk("relock.a", Locked, 0);
    step(1, 3'b001); chk("relock.b", Locked, 0);
    step(1, 3'b010); chk("relock.c", Locked, 0);
    step(1, 3'b011); outs("relock", 1, 0, 3, 0, 0, 1);

    // Binary wrap, then an Enable gap ending at 010
    for (int i = 0; i < 7; i++) begin
      step(1, bseq[i]);
      chk($sformatf("bwrap.pos%0d", i), Position, (i + 4) % 8);
      chk($sformatf("bwrap.wrap%0d", i), WrapPulse, (i == 4) ? 1 : 0);
    end
    step(0, 3'b111); outs("gap1", 1, 0, 2, 0, 0, 1);
    step(0, 3'b000); outs("gap2", 1, 0, 2, 0, 0, 1);
    step(0, 3'b101); outs("gap3", 1, 0, 2, 0, 0, 1);
    step(1, 3'b011); outs("gap.resume", 1, 0, 3, 0, 0, 1);

    // Second error, relock, then reset mid-operation
    step(1, 3'b110); outs("err2", 0, 0, 0, 1, 0, 2);
    for (int i = 0; i < 5; i++) step(1, relock[i]);
    outs("err2.relock", 1, 0, 3, 0, 0, 2);
    nReset = 1'b0;
    step(1, 3'b100);
    nReset = 1'b1;
    outs("midreset", 0, 0, 0, 0, 0, 0);
    chk("midreset.sat_ErrCount", s_ErrCount, 0);
    step(1, 3'b000);
    step(1, 3'b001);
    step(1, 3'b010);
    step(1, 3'b011); chk("midreset.acq", Locked, 0);
    step(1, 3'b100); outs("midreset.lock", 1, 0, 4, 0, 0, 0);

    // Repeated lock/error cycles to saturate the 2-bit counter
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) begin
        for (int i = 0; i < 5; i++) step(1, relock[i]);
        chk($sformatf("sat%0d.Locked", k), Locked, 1);
      end
      step(1, 3'b110);
      chk($sformatf("sat%0d.SeqError", k), SeqError, 1);
      chk($sformatf("sat%0d.sat_SeqError", k), s_SeqError, 1);
      chk($sformatf("sat%0d.ErrCount", k), ErrCount, k);
      chk($sformatf("sat%0d.sat_ErrCount", k), s_ErrCount, (k > 3) ? 3 : k);
    end

    // Gray lock and Gray wrap
    nReset = 1'b0;
    step(1, 3'b000);
    nReset = 1'b1;
    step(1, 3'b000);
    step(1, 3'b001);
    step(1, 3'b011); chk("gray.acq1", Locked, 0);
    step(1, 3'b010); chk("gray.acq2", Locked, 0);
    step(1, 3'b110); outs("gray.lock", 1, 1, 4, 0, 0, 0);
    step(1, 3'b111); outs("gray.pos5", 1, 1, 5, 0, 0, 0);
    step(1, 3'b101); outs("gray.pos6", 1, 1, 6, 0, 0, 0);
    step(1, 3'b100); outs("gray.pos7", 1, 1, 7, 0, 0, 0);
    step(1, 3'b000); outs("gray.wrap", 1, 1, 0, 0, 1, 0);
    step(1, 3'b001); outs("gray.pos1", 1, 1, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
